// File: rtl/fifo_fill_pkg.sv
// rtl/fifo_fill_pkg.sv - shared types and constants for the fifo_fill burst writer
package fifo_fill_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A run with no words to write skips RUN and reports completion directly.
  function automatic logic is_zero_len(input logic [CNT_W-1:0] size_v,
                                       input logic [CNT_W-1:0] times_v);
    return (size_v == '0) || (times_v == '0);
  endfunction

endpackage

// File: rtl/fifo_fill_if.sv
// rtl/fifo_fill_if.sv - FIFO write-side bundle between fifo_fill and the target FIFO
interface fifo_fill_if #(
  parameter int WIDTH = 8
);

  logic             fifo_wr_en;
  logic [WIDTH-1:0] fifo_wr_data;
  logic             fifo_full;

  modport master (
    output fifo_wr_en,
    output fifo_wr_data,
    input  fifo_full
  );

  modport slave (
    input  fifo_wr_en,
    input  fifo_wr_data,
    output fifo_full
  );

endinterface

// File: rtl/fifo_fill.sv
// rtl/fifo_fill.sv - writes times bursts of size incrementing words into a FIFO; FIFO_FILL_STALL_CNT_EN adds stall_count
module fifo_fill
  import fifo_fill_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic             ap_done,
  input  logic [CNT_W-1:0] size,
  input  logic [CNT_W-1:0] times,
  input  logic [WIDTH-1:0] seed,
`ifdef FIFO_FILL_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_count,
`endif
  fifo_fill_if.master      fifo
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] size_q;
  logic [CNT_W-1:0] times_q;
  logic [CNT_W-1:0] size_cnt_q;
  logic [CNT_W-1:0] times_cnt_q;
  logic [WIDTH-1:0] data_q;

  logic wr_en;
  logic start_accept;
  logic burst_end;
  logic last_write;
  logic idle_raw;
  logic ready_raw;
  logic done_raw;

  // Counters are zero-based internally: size_cnt_q == size_q-1 marks the final word of a burst.
  assign burst_end = (size_cnt_q == size_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    wr_en        = 1'b0;
    start_accept = 1'b0;
    last_write   = 1'b0;
    idle_raw     = 1'b0;
    ready_raw    = 1'b0;
    done_raw     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idle_raw = 1'b1;
        if (ap_start) begin
          ready_raw    = 1'b1;
          start_accept = 1'b1;
          state_d      = is_zero_len(size, times) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        wr_en      = !fifo.fifo_full;
        last_write = wr_en && burst_end && (times_cnt_q == times_q - CNT_W'(1));
        if (last_write) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_raw = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= ST_IDLE;
      size_q      <= '0;
      times_q     <= '0;
      size_cnt_q  <= '0;
      times_cnt_q <= '0;
      data_q      <= '0;
    end else begin
      state_q <= state_d;
      if (start_accept) begin
        size_q      <= size;
        times_q     <= times;
        size_cnt_q  <= '0;
        times_cnt_q <= '0;
        data_q      <= seed;
      end else if (wr_en) begin
        data_q <= data_q + WIDTH'(1);
        if (burst_end) begin
          size_cnt_q  <= '0;
          times_cnt_q <= times_cnt_q + CNT_W'(1);
        end else begin
          size_cnt_q <= size_cnt_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef FIFO_FILL_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      stall_cnt_q <= '0;
    end else if (start_accept) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ST_RUN) && fifo.fifo_full && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_count = ap_rst_n ? stall_cnt_q : '0;
`endif

  // Reset forces a quiet, idle-looking face regardless of register contents.
  assign ap_idle           = !ap_rst_n || idle_raw;
  assign ap_ready          = ap_rst_n && ready_raw;
  assign ap_done           = ap_rst_n && done_raw;
  assign fifo.fifo_wr_en   = ap_rst_n && wr_en;
  assign fifo.fifo_wr_data = ap_rst_n ? data_q : '0;

endmodule

// File: tb/tb_fifo_fill.sv
// tb/tb_fifo_fill.sv - self-checking bench for fifo_fill with a word-stream model and directed runs
module tb_fifo_fill;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_ready;
  logic        ap_done;
  logic [31:0] size;
  logic [31:0] times;
  logic [7:0]  seed;
`ifdef FIFO_FILL_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  fifo_fill_if #(.WIDTH(8)) fifo_if ();

  fifo_fill #(.WIDTH(8)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .size        (size),
    .times       (times),
    .seed        (seed),
`ifdef FIFO_FILL_STALL_CNT_EN
    .stall_count (stall_count),
`endif
    .fifo        (fifo_if)
  );

  always #5 ap_clk = ~ap_clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: after a start, size*times words of seed, seed+1, ... must leave, one per non-full cycle.
  longint     m_rem      = 0;
  logic [7:0] m_next     = 8'h00;
  bit         m_done_due = 1'b0;

  logic [7:0] wr_log[$];
  int         wr_cyc[$];
  int         ready_cyc[$];
  int         done_cyc[$];

  always @(negedge ap_clk) begin : compare
    bit last_now;
    bit idle_exp;
    if (!ap_rst_n) begin
      chk("rst_wr_en",   fifo_if.fifo_wr_en,   1'b0);
      chk("rst_wr_data", fifo_if.fifo_wr_data, 8'h00);
      chk("rst_ready",   ap_ready,             1'b0);
      chk("rst_done",    ap_done,              1'b0);
      chk("rst_idle",    ap_idle,              1'b1);
      m_rem      = 0;
      m_done_due = 1'b0;
    end else begin
      last_now = 1'b0;
      idle_exp = !((m_rem > 0) || m_done_due);
      if (m_rem > 0) begin
        chk("wr_en_run", fifo_if.fifo_wr_en, !fifo_if.fifo_full);
        if (fifo_if.fifo_wr_en) begin
          chk("wr_data", fifo_if.fifo_wr_data, m_next);
          wr_log.push_back(fifo_if.fifo_wr_data);
          wr_cyc.push_back(cyc);
          m_next   = m_next + 8'd1;
          m_rem    = m_rem - 1;
          last_now = (m_rem == 0);
        end
      end else begin
        chk("wr_en_quiet", fifo_if.fifo_wr_en, 1'b0);
      end
      chk("ap_done", ap_done, m_done_due);
      if (ap_done) done_cyc.push_back(cyc);
      chk("ap_idle", ap_idle, idle_exp);
      chk("ap_ready", ap_ready, idle_exp && ap_start);
      if (ap_ready) begin
        m_rem    = longint'(size) * longint'(times);
        m_next   = seed;
        last_now = (m_rem == 0);
        ready_cyc.push_back(cyc);
      end
      m_done_due = last_now;
    end
  end

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    ready_cyc.delete();
    done_cyc.delete();
  endtask

  // mode 0: never full; 1: full for 3 cycles after the 2nd write; 2: random 25% full
  task automatic run(input logic [31:0] s, input logic [31:0] t, input logic [7:0] sd,
                     input int mode, input int budget);
    int d0;
    int stall_left;
    bit stalled;
    d0         = done_cyc.size();
    stall_left = 0;
    stalled    = 1'b0;
    size       = s;
    times      = t;
    seed       = sd;
    ap_start   = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    for (int i = 0; i < budget && done_cyc.size() == d0; i++) begin
      if (mode == 1) begin
        if (wr_log.size() == 2 && !stalled) begin
          stall_left = 3;
          stalled    = 1'b1;
        end
        fifo_if.fifo_full = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end else if (mode == 2) begin
        fifo_if.fifo_full = ($urandom_range(3) == 0);
      end else begin
        fifo_if.fifo_full = 1'b0;
      end
      @(posedge ap_clk); #1;
    end
    fifo_if.fifo_full = 1'b0;
    chk("run_done_seen", done_cyc.size() > d0, 1'b1);
  endtask

  logic [7:0] e029[8];
  int         guard;

  initial begin
    e029 = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    size     = 32'd0;
    times    = 32'd0;
    seed     = 8'h00;
    fifo_if.fifo_full = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("post_rst_idle", ap_idle, 1'b1);
    chk("post_rst_data", fifo_if.fifo_wr_data, 8'h00);
    @(posedge ap_clk); #1;

    // Two bursts of four with a wrapping seed
    clear_logs();
    run(32'd4, 32'd2, 8'hFE, 0, 100);
    chk("t029_count", wr_log.size(), 8);
    if (wr_log.size() == 8 && ready_cyc.size() == 1 && done_cyc.size() == 1) begin
      for (int i = 0; i < 8; i++) chk("t029_data", wr_log[i], e029[i]);
      chk("t029_contig",    wr_cyc[7] - wr_cyc[0], 7);
      chk("t029_first_lat", wr_cyc[0] - ready_cyc[0], 1);
      chk("t029_done_lat",  done_cyc[0] - wr_cyc[7], 1);
    end

    // Stall for three cycles after the second write
    clear_logs();
    run(32'd3, 32'd1, 8'h05, 1, 100);
    chk("t030_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("t030_d0", wr_log[0], 8'h05);
      chk("t030_d1", wr_log[1], 8'h06);
      chk("t030_d2", wr_log[2], 8'h07);
      chk("t030_gap", wr_cyc[2] - wr_cyc[1], 4);
    end
`ifdef FIFO_FILL_STALL_CNT_EN
    chk("t030_stall_count", stall_count, 32'd3);
`endif

    // Zero-length runs
    clear_logs();
    run(32'd0, 32'd5, 8'h11, 0, 20);
    chk("t031_writes", wr_log.size(), 0);
    if (ready_cyc.size() == 1 && done_cyc.size() == 1)
      chk("t031_done_lat", done_cyc[0] - ready_cyc[0], 1);
    clear_logs();
    run(32'd3, 32'd0, 8'h22, 0, 20);
    chk("t031_times0_writes", wr_log.size(), 0);

    // Reset in the middle of a run
    clear_logs();
    size = 32'd16; times = 32'd4; seed = 8'h20; ap_start = 1'b1;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    guard = 0;
    while (wr_log.size() < 10 && guard < 100) begin
      @(posedge ap_clk); #1;
      guard++;
    end
    chk("t032_reached_10", wr_log.size(), 10);
    ap_rst_n = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (20) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("t032_writes_stopped", wr_log.size(), 10);
    chk("t032_no_done", done_cyc.size(), 0);
    chk("t032_idle", ap_idle, 1'b1);
    @(posedge ap_clk); #1;
    clear_logs();
    run(32'd3, 32'd2, 8'h00, 0, 50);
    chk("t032_restart_count", wr_log.size(), 6);
    if (wr_log.size() == 6) begin
      chk("t032_restart_first", wr_log[0], 8'h00);
      chk("t032_restart_last",  wr_log[5], 8'h05);
    end

    // ap_start held high: back-to-back runs re-sample the seed
    clear_logs();
    size = 32'd2; times = 32'd1; seed = 8'h40; ap_start = 1'b1;
    guard = 0;
    while (done_cyc.size() < 2 && guard < 40) begin
      @(posedge ap_clk); #1;
      if (ready_cyc.size() >= 1) seed = 8'h80;
      guard++;
    end
    ap_start = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("t033_runs", done_cyc.size(), 2);
    chk("t033_readies", ready_cyc.size(), 2);
    chk("t033_count", wr_log.size(), 4);
    if (wr_log.size() == 4 && done_cyc.size() == 2 && ready_cyc.size() == 2) begin
      chk("t033_d0", wr_log[0], 8'h40);
      chk("t033_d1", wr_log[1], 8'h41);
      chk("t033_d2", wr_log[2], 8'h80);
      chk("t033_d3", wr_log[3], 8'h81);
      chk("t033_ready_after_done", ready_cyc[1] - done_cyc[0], 1);
    end

    // Random 25% back-pressure
    clear_logs();
    run(32'd7, 32'd3, 8'hF0, 2, 400);
    repeat (3) @(posedge ap_clk);
    #1;
    chk("t034_count", wr_log.size(), 21);
    chk("t034_dones", done_cyc.size(), 1);
    if (wr_log.size() == 21) chk("t034_last", wr_log[20], 8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
